rf_wport_arbiter: RTL and testbench

Single-write-port arbiter for the integer register file in the pipelined core. It sits after the write-back stage and merges two writers: the in-order pipeline write-back result and out-of-order completions from the multi-cycle multiply/divide unit (MDU). MDU results queue in a small FIFO. The arbiter exports a pending-register mask so the hazard unit can interlock on queued writes. A starvation counter stalls write-back so that queued MDU results always drain.

---
 rtl/rf_wport_arbiter.sv | 117 +++++++++++
 tb/tb_rf_wport_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - register-file write-port arbiter merging write-back and queued MDU results
module rf_wport_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_valD,
  output logic            wb_stall,
  input  logic            mdu_valid,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            mdu_ready,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     busy_mask
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [PW-1:0]   rptr;
  logic [PW-1:0]   wptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt;

  logic pipe_req;
  logic fifo_ne;
  logic grant_pipe;
  logic pop;
  logic push;

  // Grant decision: pipeline first unless the queued head has starved long enough.
  // Writes to x0 are never requests, so they are swallowed without blocking the FIFO.
  always_comb begin
    pipe_req   = wb_wen & (wb_rd != 5'd0);
    fifo_ne    = (count != '0);
    wb_stall   = fifo_ne & pipe_req & (starve_cnt == SW'(STARVE_LIMIT));
    grant_pipe = pipe_req & ~wb_stall;
    pop        = ~grant_pipe & fifo_ne;
    mdu_ready  = (count < CW'(DEPTH));
    push       = mdu_valid & mdu_ready & (mdu_rd != 5'd0);
  end

  // FIFO payload storage; contents are only meaningful under count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr]   <= mdu_rd;
      data_q[wptr] <= mdu_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep count steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Starvation counter: counts pipeline wins over a waiting head, cleared on pop or when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!fifo_ne || pop) begin
      starve_cnt <= '0;
    end else if (grant_pipe && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Registered write port; address and data hold their last value when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= grant_pipe | pop;
      if (grant_pipe) begin
        rf_waddr <= wb_rd;
        rf_wdata <= wb_valD;
      end else if (pop) begin
        rf_waddr <= rd_q[rptr];
        rf_wdata <= data_q[rptr];
      end
    end
  end

  // Pending-write mask: one-hot of rd over every occupied slot from the head onward.
  always_comb begin
    busy_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) begin
        busy_mask[rd_q[rptr + PW'(k)]] = 1'b1;
      end
    end
    busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb/tb_rf_wport_arbiter.sv - self-checking bench for rf_wport_arbiter
module tb_rf_wport_arbiter;
  localparam int DEPTH = 2;
  localparam int LIM   = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_wen;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_valD;
  logic            wb_stall;
  logic            mdu_valid;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_data;
  logic            mdu_ready;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     busy_mask;

  rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_valD(wb_valD), .wb_stall(wb_stall),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue of pending MDU writes plus a starvation tally.
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  int          starve = 0;
  logic        e_wen = 1'b0;
  logic [4:0]  e_waddr = 5'd0;
  logic [31:0] e_wdata = 32'd0;
  logic        e_stall;
  logic        e_ready;
  logic [31:0] e_mask;

  task automatic model_outputs();
    logic preq;
    preq    = wb_wen && (wb_rd != 5'd0);
    e_ready = (mq.size() < DEPTH);
    e_stall = (mq.size() > 0) && preq && (starve == LIM);
    e_mask  = 32'd0;
    foreach (mq[i]) e_mask[mq[i].rd] = 1'b1;
  endtask

  task automatic tick();
    logic preq;
    logic ne;
    ent_t e;
    model_outputs();
    if (rst) begin
      mq.delete();
      starve = 0;
      e_wen = 1'b0; e_waddr = 5'd0; e_wdata = 32'd0;
    end else begin
      preq = wb_wen && (wb_rd != 5'd0);
      ne   = (mq.size() > 0);
      if (preq && !e_stall) begin
        e_wen = 1'b1; e_waddr = wb_rd; e_wdata = wb_valD;
        if (ne && starve < LIM) starve++;
      end else if (ne) begin
        e_wen = 1'b1; e_waddr = mq[0].rd; e_wdata = mq[0].data;
        mq.delete(0);
        starve = 0;
      end else begin
        e_wen = 1'b0;
      end
      if (!ne) starve = 0;
      if (mdu_valid && e_ready && mdu_rd != 5'd0) begin
        e.rd = mdu_rd; e.data = mdu_data;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] r, input logic [31:0] d,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    wb_wen = w; wb_rd = r; wb_valD = d;
    mdu_valid = mv; mdu_rd = mr; mdu_data = md;
    #1;
    model_outputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    n_cmp++;
    if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      n_bad++; $display("FAIL reset_rf: got wen=%0b addr=%0d data=%0h want 0/0/0", rf_wen, rf_waddr, rf_wdata);
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (busy_mask !== 32'd0 || mdu_ready !== 1'b1 || wb_stall !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags: got mask=%0h ready=%0b stall=%0b want 0/1/0", busy_mask, mdu_ready, wb_stall);
    end
  endtask

  task automatic test_pipeline_only();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5, 32'h1234, 0, 0, 0);
      n_cmp++;
      if (wb_stall !== 1'b0) begin
        n_bad++; $display("FAIL pipe_stall: got %0b want 0", wb_stall);
      end
      tick();
      n_cmp++;
      if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
        n_bad++; $display("FAIL pipe_write: got wen=%0b addr=%0d data=%0h want 1/5/1234", rf_wen, rf_waddr, rf_wdata);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    n_cmp++;
    if (rf_wen !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
      n_bad++; $display("FAIL pipe_idle_hold: got wen=%0b addr=%0d data=%0h want 0/5/1234", rf_wen, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_mdu_only();
    drive(0, 0, 0, 1, 7, 32'hDEADBEEF);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (busy_mask !== 32'h80 || rf_wen !== 1'b0) begin
      n_bad++; $display("FAIL mdu_n1: got mask=%0h wen=%0b want 80/0", busy_mask, rf_wen);
    end
    tick();
    n_cmp++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEADBEEF || busy_mask !== 32'd0) begin
      n_bad++; $display("FAIL mdu_n2: got wen=%0b addr=%0d data=%0h mask=%0h want 1/7/deadbeef/0",
                        rf_wen, rf_waddr, rf_wdata, busy_mask);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic [4:0]  xa[8] = '{9, 9, 9, 9, 3, 9, 9, 9};
    logic [31:0] xd[8] = '{32'h900, 32'h901, 32'h902, 32'h903, 32'h33, 32'h904, 32'h905, 32'h906};
    logic [4:0]  wa[$];
    logic [31:0] wd[$];
    int k = 0;
    int stalls = 0;
    drive(0, 0, 0, 1, 3, 32'h33);
    tick();
    for (int c = 0; c < 8; c++) begin
      drive(1, 9, 32'h900 + k, 0, 0, 0);
      n_cmp++;
      if (wb_stall !== (c == 4)) begin
        n_bad++; $display("FAIL starve_stall c%0d: got %0b want %0b", c, wb_stall, (c == 4));
      end
      if (wb_stall) stalls++; else k++;
      tick();
      if (rf_wen) begin wa.push_back(rf_waddr); wd.push_back(rf_wdata); end
    end
    n_cmp++;
    if (stalls != 1 || wa.size() != 8) begin
      n_bad++; $display("FAIL starve_counts: got stalls=%0d writes=%0d want 1/8", stalls, wa.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (wa[i] !== xa[i] || wd[i] !== xd[i]) begin
          n_bad++; $display("FAIL starve_order[%0d]: got %0d/%0h want %0d/%0h", i, wa[i], wd[i], xa[i], xd[i]);
        end
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_fifo_full();
    logic       rdy_log[20];
    logic [4:0] mw[$];
    int mi = 0;
    int acc3 = -1;
    int stalls = 0;
    int pipe_w = 0;
    logic mv;
    for (int c = 0; c < 23; c++) begin
      mv = (mi < 3);
      if (c < 20) drive(1, 20, 32'hAAAA, mv, 5'(10 + mi), 32'h100 + mi);
      else        drive(0, 0, 0, 0, 0, 0);
      if (c < 20) rdy_log[c] = mdu_ready;
      if (mv && mdu_ready) begin
        if (mi == 2) acc3 = c;
        mi++;
      end
      if (wb_stall) stalls++;
      tick();
      if (rf_wen) begin
        if (rf_waddr == 5'd20) pipe_w++;
        else mw.push_back(rf_waddr);
      end
    end
    n_cmp++;
    if (rdy_log[1] !== 1'b1 || rdy_log[2] !== 1'b0 || rdy_log[5] !== 1'b0 || rdy_log[6] !== 1'b1) begin
      n_bad++; $display("FAIL full_ready: got c1=%0b c2=%0b c5=%0b c6=%0b want 1/0/0/1",
                        rdy_log[1], rdy_log[2], rdy_log[5], rdy_log[6]);
    end
    n_cmp++;
    if (acc3 != 6) begin
      n_bad++; $display("FAIL full_third_push: got cycle %0d want 6", acc3);
    end
    n_cmp++;
    if (stalls != 3 || pipe_w != 17) begin
      n_bad++; $display("FAIL full_counts: got stalls=%0d pipe=%0d want 3/17", stalls, pipe_w);
    end
    n_cmp++;
    if (mw.size() != 3) begin
      n_bad++; $display("FAIL full_mdu_count: got %0d want 3", mw.size());
    end else if (mw[0] !== 5'd10 || mw[1] !== 5'd11 || mw[2] !== 5'd12) begin
      n_bad++; $display("FAIL full_order: got %0d,%0d,%0d want 10,11,12", mw[0], mw[1], mw[2]);
    end
  endtask

  task automatic test_x0();
    drive(0, 0, 0, 1, 4, 32'h44);
    tick();
    drive(1, 0, 32'hBAD, 0, 0, 0);
    n_cmp++;
    if (wb_stall !== 1'b0) begin
      n_bad++; $display("FAIL x0_wb_stall: got %0b want 0", wb_stall);
    end
    tick();
    n_cmp++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h44) begin
      n_bad++; $display("FAIL x0_wb_head: got wen=%0b addr=%0d data=%0h want 1/4/44", rf_wen, rf_waddr, rf_wdata);
    end
    drive(0, 0, 0, 1, 0, 32'h55);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (busy_mask !== 32'd0 || mdu_ready !== 1'b1 || rf_wen !== 1'b0) begin
      n_bad++; $display("FAIL x0_mdu_push: got mask=%0h ready=%0b wen=%0b want 0/1/0", busy_mask, mdu_ready, rf_wen);
    end
    tick();
    n_cmp++;
    if (rf_wen !== 1'b0) begin
      n_bad++; $display("FAIL x0_mdu_write: got wen=%0b want 0", rf_wen);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 21, 32'h1, 1, 5, 32'h55); tick();
    drive(1, 21, 32'h2, 1, 6, 32'h66); tick();
    drive(1, 21, 32'h3, 0, 0, 0);      tick();
    drive(1, 21, 32'h4, 0, 0, 0);      tick();
    rst = 1'b1;
    drive(1, 21, 32'h5, 0, 0, 0);
    n_cmp++;
    if (busy_mask !== 32'h60 || wb_stall !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_pre: got mask=%0h stall=%0b want 60/0", busy_mask, wb_stall);
    end
    tick();
    rst = 1'b0;
    drive(1, 21, 32'h6, 0, 0, 0);
    n_cmp++;
    if (rf_wen !== 1'b0 || busy_mask !== 32'd0 || mdu_ready !== 1'b1 || wb_stall !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_post: got wen=%0b mask=%0h ready=%0b stall=%0b want 0/0/1/0",
                        rf_wen, busy_mask, mdu_ready, wb_stall);
    end
    tick();
    n_cmp++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd21 || rf_wdata !== 32'h6) begin
      n_bad++; $display("FAIL rstmid_pipe: got wen=%0b addr=%0d data=%0h want 1/21/6", rf_wen, rf_waddr, rf_wdata);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      tick();
      n_cmp++;
      if (rf_wen !== 1'b0) begin
        n_bad++; $display("FAIL rstmid_stale c%0d: got wen=%0b addr=%0d want 0", i, rf_wen, rf_waddr);
      end
    end
  endtask

  task automatic test_random();
    logic hold_wb = 1'b0;
    logic hold_mdu = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!hold_wb) begin
        wb_wen  = ($urandom_range(0, 2) != 0);
        wb_rd   = 5'($urandom_range(0, 7));
        wb_valD = $urandom;
      end
      if (!hold_mdu) begin
        mdu_valid = ($urandom_range(0, 1) != 0);
        mdu_rd    = 5'($urandom_range(0, 7));
        mdu_data  = $urandom;
      end
      #1;
      model_outputs();
      n_cmp++;
      if (wb_stall !== e_stall || mdu_ready !== e_ready || busy_mask !== e_mask) begin
        n_bad++; $display("FAIL rand_comb c%0d: got stall=%0b ready=%0b mask=%0h want %0b/%0b/%0h",
                          c, wb_stall, mdu_ready, busy_mask, e_stall, e_ready, e_mask);
      end
      n_cmp++;
      if (rf_wen !== e_wen || rf_waddr !== e_waddr || rf_wdata !== e_wdata) begin
        n_bad++; $display("FAIL rand_rf c%0d: got %0b/%0d/%0h want %0b/%0d/%0h",
                          c, rf_wen, rf_waddr, rf_wdata, e_wen, e_waddr, e_wdata);
      end
      hold_wb  = e_stall && !rst;
      hold_mdu = mdu_valid && !e_ready && !rst;
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wb_wen = 0; wb_rd = 0; wb_valD = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    test_reset();
    test_pipeline_only();
    test_mdu_only();
    test_starvation();
    test_fifo_full();
    test_x0();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
